// File: rtl/avmm_burst_pipe_bridge.sv
// avmm_burst_pipe_bridge: fully registered Avalon-MM pipeline bridge.
// A two-entry command buffer decouples s0 from m0. Reads are issued only
// while the outstanding-beat credit allows. Read responses are returned
// through a single register stage.
module avmm_burst_pipe_bridge #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 18,
    parameter int BURST_W  = 4,
    parameter int MAX_PEND = 32
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [ADDR_W-1:0]             s0_address,
    input  logic                          s0_read,
    input  logic                          s0_write,
    input  logic                          s0_debugaccess,
    input  logic [DATA_W-1:0]             s0_writedata,
    input  logic [DATA_W/8-1:0]           s0_byteenable,
    input  logic [BURST_W-1:0]            s0_burstcount,
    output logic                          s0_waitrequest,
    output logic [DATA_W-1:0]             s0_readdata,
    output logic                          s0_readdatavalid,
    output logic [ADDR_W-1:0]             m0_address,
    output logic                          m0_read,
    output logic                          m0_write,
    output logic [DATA_W-1:0]             m0_writedata,
    output logic [DATA_W/8-1:0]           m0_byteenable,
    output logic [BURST_W-1:0]            m0_burstcount,
    output logic                          m0_debugaccess,
    input  logic                          m0_waitrequest,
    input  logic [DATA_W-1:0]             m0_readdata,
    input  logic                          m0_readdatavalid,
    output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt,
    output logic                          err_unexp_rsp
);
    localparam int BE_W   = DATA_W / 8;
    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int SUM_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

    // A read may go out only if its whole burst fits in the remaining credit.
    function automatic logic credit_ok(input logic [PEND_W-1:0] pend,
                                       input logic [BURST_W-1:0] bc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(pend) + SUM_W'(bc);
        return sum <= SUM_W'(MAX_PEND);
    endfunction

    logic                wait_q;
    logic [1:0]          cmd_cnt;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [ADDR_W-1:0]   addr_q  [2];
    logic                rd_q    [2];
    logic                wr_q    [2];
    logic [DATA_W-1:0]   wdata_q [2];
    logic [BE_W-1:0]     be_q    [2];
    logic [BURST_W-1:0]  bc_q    [2];
    logic                dbg_q   [2];
    logic [BURST_W-1:0]  wbeat_left;
    logic [ADDR_W-1:0]   burst_addr_q;
    logic [BURST_W-1:0]  burst_bc_q;
    logic [DATA_W-1:0]   rsp_data_p1;
    logic                rsp_vld_p1;

    logic                accept;
    logic                pop;
    logic                head_vld;
    logic                issue;
    logic                rsp_ok;
    logic [ADDR_W-1:0]   enq_addr;
    logic [BURST_W-1:0]  enq_bc;
    logic [1:0]          cmd_cnt_nxt;
    logic [PEND_W-1:0]   pend_nxt;

    assign head_vld       = (cmd_cnt != 2'd0);
    assign m0_read        = head_vld & rd_q[rd_ptr] & credit_ok(pend_cnt, bc_q[rd_ptr]);
    assign m0_write       = head_vld & wr_q[rd_ptr];
    assign m0_address     = addr_q[rd_ptr];
    assign m0_writedata   = wdata_q[rd_ptr];
    assign m0_byteenable  = be_q[rd_ptr];
    assign m0_burstcount  = bc_q[rd_ptr];
    assign m0_debugaccess = dbg_q[rd_ptr];

    assign s0_waitrequest   = wait_q;
    assign s0_readdata      = rsp_data_p1;
    assign s0_readdatavalid = rsp_vld_p1;

    assign accept = (s0_read | s0_write) & ~wait_q;
    assign pop    = (m0_read | m0_write) & ~m0_waitrequest;
    assign issue  = m0_read & ~m0_waitrequest;
    assign rsp_ok = m0_readdatavalid & (pend_cnt != '0);

    // Next-state of the buffer occupancy and read credit, plus the fields
    // stored for follow-on write beats (taken from the burst's first beat).
    always_comb begin
        enq_addr = s0_address;
        enq_bc   = s0_burstcount;
        if (s0_write && (wbeat_left != '0)) begin
            enq_addr = burst_addr_q;
            enq_bc   = burst_bc_q;
        end
        cmd_cnt_nxt = cmd_cnt + {1'b0, accept} - {1'b0, pop};
        pend_nxt    = pend_cnt;
        if (issue)
            pend_nxt = pend_nxt + PEND_W'(bc_q[rd_ptr]);
        if (rsp_ok)
            pend_nxt = pend_nxt - PEND_W'(1);
    end

    // Command buffer: two entries, written at wr_ptr, drained from rd_ptr.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            cmd_cnt <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            wait_q  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                addr_q[i]  <= '0;
                rd_q[i]    <= 1'b0;
                wr_q[i]    <= 1'b0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
                bc_q[i]    <= '0;
                dbg_q[i]   <= 1'b0;
            end
        end else begin
            cmd_cnt <= cmd_cnt_nxt;
            wait_q  <= (cmd_cnt_nxt == 2'd2);
            if (accept) begin
                addr_q[wr_ptr]  <= enq_addr;
                rd_q[wr_ptr]    <= s0_read;
                wr_q[wr_ptr]    <= s0_write;
                wdata_q[wr_ptr] <= s0_writedata;
                be_q[wr_ptr]    <= s0_byteenable;
                bc_q[wr_ptr]    <= enq_bc;
                dbg_q[wr_ptr]   <= s0_debugaccess;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

    // Write-beat counter: latches the first beat's burst header and counts
    // the beats still to come (an illegal count of 0 is a single beat).
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wbeat_left   <= '0;
            burst_addr_q <= '0;
            burst_bc_q   <= '0;
        end else if (accept && s0_write) begin
            if (wbeat_left == '0) begin
                burst_addr_q <= s0_address;
                burst_bc_q   <= s0_burstcount;
                wbeat_left   <= (s0_burstcount == '0) ? '0 : s0_burstcount - BURST_W'(1);
            end else begin
                wbeat_left <= wbeat_left - BURST_W'(1);
            end
        end
    end

    // Outstanding read beats and the sticky unexpected-response flag.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pend_cnt      <= '0;
            err_unexp_rsp <= 1'b0;
        end else begin
            pend_cnt <= pend_nxt;
            if (m0_readdatavalid && (pend_cnt == '0))
                err_unexp_rsp <= 1'b1;
        end
    end

    // Response stage p1: one register, beats with no pending read dropped.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rsp_data_p1 <= '0;
            rsp_vld_p1  <= 1'b0;
        end else begin
            rsp_data_p1 <= m0_readdata;
            rsp_vld_p1  <= rsp_ok;
        end
    end
endmodule

// File: tb/tb_avmm_burst_pipe_bridge.sv
// Directed testbench for avmm_burst_pipe_bridge with hand-computed expectations.
module tb_avmm_burst_pipe_bridge;
    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 18;
    localparam int BURST_W  = 4;
    localparam int MAX_PEND = 32;
    localparam int BE_W     = DATA_W / 8;
    localparam int PEND_W   = $clog2(MAX_PEND + 1);
    localparam int W        = DATA_W;

    logic                clk_clk = 1'b0;
    logic                reset_reset;
    logic [ADDR_W-1:0]   s0_address;
    logic                s0_read;
    logic                s0_write;
    logic                s0_debugaccess;
    logic [DATA_W-1:0]   s0_writedata;
    logic [BE_W-1:0]     s0_byteenable;
    logic [BURST_W-1:0]  s0_burstcount;
    logic                s0_waitrequest;
    logic [DATA_W-1:0]   s0_readdata;
    logic                s0_readdatavalid;
    logic [ADDR_W-1:0]   m0_address;
    logic                m0_read;
    logic                m0_write;
    logic [DATA_W-1:0]   m0_writedata;
    logic [BE_W-1:0]     m0_byteenable;
    logic [BURST_W-1:0]  m0_burstcount;
    logic                m0_debugaccess;
    logic                m0_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;
    logic [PEND_W-1:0]   pend_cnt;
    logic                err_unexp_rsp;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic                wr;
        logic [ADDR_W-1:0]   addr;
        logic [BURST_W-1:0]  bc;
        logic [BE_W-1:0]     be;
        logic [DATA_W-1:0]   data;
    } beat_t;

    beat_t mon_q[$];

    avmm_burst_pipe_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_debugaccess(s0_debugaccess), .s0_writedata(s0_writedata),
        .s0_byteenable(s0_byteenable), .s0_burstcount(s0_burstcount),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_burstcount(m0_burstcount), .m0_debugaccess(m0_debugaccess),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .pend_cnt(pend_cnt), .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk_clk = ~clk_clk;

    // Record every command the m0 side hands over (sampled mid-cycle).
    always @(negedge clk_clk) begin
        beat_t b;
        if (!reset_reset && (m0_read || m0_write) && !m0_waitrequest) begin
            b.wr   = m0_write;
            b.addr = m0_address;
            b.bc   = m0_burstcount;
            b.be   = m0_byteenable;
            b.data = m0_writedata;
            mon_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic send_cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [BURST_W-1:0] bc);
        bit acc;
        acc = 1'b0;
        s0_read       = rd;
        s0_write      = wr;
        s0_address    = a;
        s0_writedata  = d;
        s0_burstcount = bc;
        s0_byteenable = '1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = !s0_waitrequest;
            tick();
        end
        s0_read  = 1'b0;
        s0_write = 1'b0;
        if (!acc)
            chk("accept_timeout", W'(0), W'(1));
    endtask

    task automatic ret_beats(input int n, input logic [DATA_W-1:0] d);
        m0_readdata      = d;
        m0_readdatavalid = 1'b1;
        repeat (n) tick();
        m0_readdatavalid = 1'b0;
    endtask

    initial begin
        reset_reset      = 1'b1;
        s0_address       = '0;
        s0_read          = 1'b0;
        s0_write         = 1'b0;
        s0_debugaccess   = 1'b0;
        s0_writedata     = '0;
        s0_byteenable    = '0;
        s0_burstcount    = '0;
        m0_waitrequest   = 1'b0;
        m0_readdata      = '0;
        m0_readdatavalid = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_wait",     W'(s0_waitrequest), W'(1));
        chk("rst_m0_read",  W'(m0_read),        W'(0));
        chk("rst_m0_write", W'(m0_write),       W'(0));
        chk("rst_pend",     W'(pend_cnt),       W'(0));
        chk("rst_err",      W'(err_unexp_rsp),  W'(0));
        chk("rst_rdv",      W'(s0_readdatavalid), W'(0));
        reset_reset = 1'b0;
        chk("rel_wait_pre", W'(s0_waitrequest), W'(1));
        tick();
        chk("rel_wait_post", W'(s0_waitrequest), W'(0));

        // Single read with a 3-cycle return
        send_cmd(1'b1, 1'b0, 18'h00010, '0, 4'd1);
        chk("rd1_m0_read", W'(m0_read),    W'(1));
        chk("rd1_addr",    W'(m0_address), W'(18'h00010));
        chk("rd1_bc",      W'(m0_burstcount), W'(1));
        chk("rd1_pend0",   W'(pend_cnt),   W'(0));
        tick();
        chk("rd1_m0_idle", W'(m0_read),    W'(0));
        chk("rd1_pend1",   W'(pend_cnt),   W'(1));
        tick();
        chk("rd1_no_rdv",  W'(s0_readdatavalid), W'(0));
        ret_beats(1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        chk("rd1_rdv",     W'(s0_readdatavalid), W'(1));
        chk("rd1_data",    s0_readdata, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        chk("rd1_pend_end", W'(pend_cnt),  W'(0));
        tick();
        chk("rd1_rdv_off", W'(s0_readdatavalid), W'(0));

        // Credit stall: eight bursts of 4 fill the credit exactly
        for (int i = 0; i < 8; i++)
            send_cmd(1'b1, 1'b0, ADDR_W'(i * 16), '0, 4'd4);
        tick();
        tick();
        chk("cr_pend32", W'(pend_cnt), W'(32));
        send_cmd(1'b1, 1'b0, 18'h00080, '0, 4'd4);
        chk("cr_hold0", W'(m0_read), W'(0));
        tick();
        chk("cr_hold1", W'(m0_read), W'(0));
        chk("cr_hold_pend", W'(pend_cnt), W'(32));
        ret_beats(1, 128'h1);
        chk("cr_one_beat_pend", W'(pend_cnt), W'(31));
        chk("cr_one_beat_hold", W'(m0_read),  W'(0));
        ret_beats(3, 128'h2);
        chk("cr_pend28",   W'(pend_cnt),   W'(28));
        chk("cr_release",  W'(m0_read),    W'(1));
        chk("cr_rel_addr", W'(m0_address), W'(18'h00080));
        tick();
        chk("cr_reissue_pend", W'(pend_cnt), W'(32));
        ret_beats(32, 128'h3);
        chk("cr_drain", W'(pend_cnt), W'(0));

        // Backpressure: m0 stalled for 10 cycles while s0 writes back-to-back
        repeat (2) tick();
        mon_q.delete();
        m0_waitrequest = 1'b1;
        send_cmd(1'b0, 1'b1, 18'h00040, W'(32'h100), 4'd1);
        chk("bp_wait_after1", W'(s0_waitrequest), W'(0));
        send_cmd(1'b0, 1'b1, 18'h00041, W'(32'h101), 4'd1);
        chk("bp_wait_after2", W'(s0_waitrequest), W'(1));
        chk("bp_m0_write",    W'(m0_write),       W'(1));
        fork
            begin
                for (int i = 2; i < 5; i++)
                    send_cmd(1'b0, 1'b1, ADDR_W'(32'h40 + i), W'(32'h100 + i), 4'd1);
            end
            begin
                repeat (8) tick();
                m0_waitrequest = 1'b0;
            end
        join
        repeat (5) tick();
        chk("bp_count", W'(mon_q.size()), W'(5));
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            chk("bp_wr",   W'(mon_q[i].wr),   W'(1));
            chk("bp_addr", W'(mon_q[i].addr), W'(32'h40 + i));
            chk("bp_data", mon_q[i].data,     W'(32'h100 + i));
        end

        // Write burst of 4 followed by a read
        mon_q.delete();
        for (int i = 0; i < 4; i++)
            send_cmd(1'b0, 1'b1, 18'h00200, W'(32'hA0 + i), 4'd4);
        send_cmd(1'b1, 1'b0, 18'h00300, '0, 4'd1);
        repeat (4) tick();
        chk("wb_count", W'(mon_q.size()), W'(5));
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            chk("wb_wr",   W'(mon_q[i].wr),   W'(1));
            chk("wb_addr", W'(mon_q[i].addr), W'(18'h00200));
            chk("wb_bc",   W'(mon_q[i].bc),   W'(4));
            chk("wb_be",   W'(mon_q[i].be),   W'(16'hFFFF));
            chk("wb_data", mon_q[i].data,     W'(32'hA0 + i));
        end
        if (mon_q.size() == 5) begin
            chk("wb_rd_last", W'(mon_q[4].wr),   W'(0));
            chk("wb_rd_addr", W'(mon_q[4].addr), W'(18'h00300));
        end
        chk("wb_pend", W'(pend_cnt), W'(1));
        ret_beats(1, 128'h5);
        chk("wb_pend_end", W'(pend_cnt), W'(0));
        tick();

        // Unexpected response
        ret_beats(1, 128'hBAD);
        chk("ux_err",  W'(err_unexp_rsp),    W'(1));
        chk("ux_rdv",  W'(s0_readdatavalid), W'(0));
        chk("ux_pend", W'(pend_cnt),         W'(0));
        repeat (2) tick();
        chk("ux_sticky", W'(err_unexp_rsp),  W'(1));

        // Mid-burst reset with 6 beats pending and a full buffer
        send_cmd(1'b1, 1'b0, 18'h00400, '0, 4'd4);
        send_cmd(1'b1, 1'b0, 18'h00410, '0, 4'd2);
        repeat (2) tick();
        chk("mr_pend6", W'(pend_cnt), W'(6));
        m0_waitrequest = 1'b1;
        send_cmd(1'b0, 1'b1, 18'h00500, W'(32'h55), 4'd1);
        send_cmd(1'b0, 1'b1, 18'h00510, W'(32'h66), 4'd1);
        chk("mr_full",  W'(s0_waitrequest), W'(1));
        chk("mr_m0_wr", W'(m0_write),       W'(1));
        #2;
        reset_reset = 1'b1;
        #1;
        chk("mr_pend",   W'(pend_cnt),       W'(0));
        chk("mr_m0_wr0", W'(m0_write),       W'(0));
        chk("mr_m0_rd0", W'(m0_read),        W'(0));
        chk("mr_addr",   W'(m0_address),     W'(0));
        chk("mr_wdata",  m0_writedata,       W'(0));
        chk("mr_err",    W'(err_unexp_rsp),  W'(0));
        chk("mr_rdv",    W'(s0_readdatavalid), W'(0));
        chk("mr_rdata",  s0_readdata,        W'(0));
        chk("mr_wait",   W'(s0_waitrequest), W'(1));
        tick();
        reset_reset    = 1'b0;
        m0_waitrequest = 1'b0;
        chk("mr_wait_pre", W'(s0_waitrequest), W'(1));
        tick();
        chk("mr_wait_post", W'(s0_waitrequest), W'(0));
        chk("mr_discard",   W'(m0_write),       W'(0));
        ret_beats(1, 128'h77);
        chk("mr_late_err",  W'(err_unexp_rsp),    W'(1));
        chk("mr_late_rdv",  W'(s0_readdatavalid), W'(0));
        chk("mr_late_pend", W'(pend_cnt),         W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
